// File: rtl/fpu_minmax16.sv
// Streaming fp16 min/max reducer: folds a packet of fp16 samples into a registered
// running minimum/maximum, sample count and NaN/number flags over valid/ready.
module fpu_minmax16 #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_min,
    output logic [15:0]        out_max,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_nan_seen,
    output logic               out_has_num
);

    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        FIRST  = 3'd0,
        WAIT   = 3'd1,
        CMPMIN = 3'd2,
        CMPMAX = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [DW-1:0]        smp, smp_d;
    logic                 lst, lst_d;
    logic [DW-1:0]        min_d, max_d;
    logic [COUNT_W-1:0]   cnt_d, cnt_inc;
    logic                 nan_d, has_d;
    logic                 in_ready_d, out_valid_d;
    logic                 accept;

    logic [DW-1:0]        fpu_in1, fpu_in2;
    logic                 cmp_lt, cmp_eq, cmp_gt;
    logic                 ordered, both_zero;
    logic [DW-1:0]        key1, key2;

    function automatic logic is_nan(input logic [DW-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    // Sign-magnitude to monotonic unsigned key so ordering is a plain compare
    function automatic logic [DW-1:0] order_key(input logic [DW-1:0] x);
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    // Comparator operands stay idle outside the two compare states
    always_comb begin
        fpu_in1 = '0;
        fpu_in2 = '0;
        if (state == CMPMIN) begin
            fpu_in1 = smp;
            fpu_in2 = out_min;
        end else if (state == CMPMAX) begin
            fpu_in1 = smp;
            fpu_in2 = out_max;
        end
    end

    // Shared fp16 comparator: NaN is unordered, signed zeros are equal
    always_comb begin
        ordered   = !is_nan(fpu_in1) && !is_nan(fpu_in2);
        both_zero = (fpu_in1[14:0] == 15'h0000) && (fpu_in2[14:0] == 15'h0000);
        key1      = order_key(fpu_in1);
        key2      = order_key(fpu_in2);
        cmp_eq    = ordered && (both_zero || (fpu_in1 == fpu_in2));
        cmp_lt    = ordered && !cmp_eq && (key1 < key2);
        cmp_gt    = ordered && !cmp_eq && !cmp_lt;
    end

    assign accept  = in_valid && in_ready;
    assign cnt_inc = (out_count == {COUNT_W{1'b1}}) ? out_count : out_count + COUNT_W'(1);

    // Next-state and accumulator update
    always_comb begin
        state_d = state;
        smp_d   = smp;
        lst_d   = lst;
        min_d   = out_min;
        max_d   = out_max;
        cnt_d   = out_count;
        nan_d   = out_nan_seen;
        has_d   = out_has_num;

        case (state)
            FIRST: begin
                if (accept) begin
                    cnt_d = COUNT_W'(1);
                    if (is_nan(in_data)) begin
                        nan_d = 1'b1;
                        has_d = 1'b0;
                        min_d = '0;
                        max_d = '0;
                    end else begin
                        min_d = in_data;
                        max_d = in_data;
                        has_d = 1'b1;
                    end
                    state_d = in_last ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (accept) begin
                    smp_d = in_data;
                    lst_d = in_last;
                    cnt_d = cnt_inc;
                    if (is_nan(in_data)) begin
                        nan_d   = 1'b1;
                        state_d = in_last ? DONE : WAIT;
                    end else if (!out_has_num) begin
                        min_d   = in_data;
                        max_d   = in_data;
                        has_d   = 1'b1;
                        state_d = in_last ? DONE : WAIT;
                    end else begin
                        state_d = CMPMIN;
                    end
                end
            end
            CMPMIN: begin
                if (cmp_lt) begin
                    min_d = smp;
                end
                state_d = CMPMAX;
            end
            CMPMAX: begin
                if (cmp_gt) begin
                    max_d = smp;
                end
                state_d = lst ? DONE : WAIT;
            end
            DONE: begin
                if (out_ready) begin
                    smp_d   = '0;
                    lst_d   = 1'b0;
                    min_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    nan_d   = 1'b0;
                    has_d   = 1'b0;
                    state_d = FIRST;
                end
            end
            default: begin
                state_d = FIRST;
            end
        endcase

        in_ready_d  = (state_d == FIRST) || (state_d == WAIT);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= FIRST;
            smp          <= '0;
            lst          <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_min      <= '0;
            out_max      <= '0;
            out_count    <= '0;
            out_nan_seen <= 1'b0;
            out_has_num  <= 1'b0;
        end else begin
            state        <= state_d;
            smp          <= smp_d;
            lst          <= lst_d;
            in_ready     <= in_ready_d;
            out_valid    <= out_valid_d;
            out_min      <= min_d;
            out_max      <= max_d;
            out_count    <= cnt_d;
            out_nan_seen <= nan_d;
            out_has_num  <= has_d;
        end
    end

endmodule
